ula_operand_sequencer: RTL
==========================

// Module: ula_operand_sequencer
// PURPOSE
//  Upstream stage of the ULA datapath: captures operand A, operand B and the opcode
//  from one shared switch bus over three successive NEXT presses.
//  Holds them stable on a_out/b_out/op_out, which drive the combinational ALU units
//  (AND/OR/XOR/adders), and pulses op_valid for the downstream result register.
//  Exposes its state to board LEDs.
// PARAMETERS
//  WIDTH            4   operand width (a_out, b_out, sw)
//  OPW              3   opcode width; opcode is taken from sw[OPW-1:0] (OPW <= WIDTH)
//  DEBOUNCE_CYCLES  16  stable-high cycles needed before a press counts (debounce build only)
// PORTS
//  clk        in   1      system clock; all state changes on rising edge
//  rst        in   1      synchronous, active-high reset
//  sw         in   WIDTH  raw switch bus (operand value or opcode)
//  btn_next   in   1      raw push button: commit current value / advance
//  btn_clear  in   1      raw push button: abort entry and return to LOAD_A
//  a_out      out  WIDTH  registered operand A
//  b_out      out  WIDTH  registered operand B
//  op_out     out  OPW    registered opcode
//  op_valid   out  1      one-cycle pulse: operands and opcode are complete and stable
//  state_out  out  3      current FSM state code (LED indicator)
// BEHAVIOUR
//  - Reset (sync, active-high): state=LOAD_A; a_out=b_out=op_out=0; op_valid=0;
//    synchroniser and edge flops=0. Reset mid-entry discards partial operands.
//  - Buttons: 2-flop synchroniser, then rising-edge detect (sync2 & ~prev), giving
//    a 1-cycle press pulse. Action lands on the 3rd rising clk edge after the raw rise.
//    A held button gives exactly one pulse.
//  - States (3-bit encoding):
//    LOAD_A=0, LOAD_B=1, LOAD_OP=2, ISSUE=3, SHOW=4.
//  - Transitions on next pulse:
//    LOAD_A: a_out<=sw, goes to LOAD_B.
//    LOAD_B: b_out<=sw, goes to LOAD_OP.
//    LOAD_OP: op_out<=sw[OPW-1:0], goes to ISSUE.
//  - ISSUE lasts exactly 1 cycle, with op_valid=1, then goes to SHOW unconditionally.
//    Button pulses during ISSUE are ignored.
//  - SHOW: outputs held. A next pulse goes to LOAD_A, and a_out/b_out/op_out keep
//    their old values until overwritten.
//  - A clear pulse in any state goes to LOAD_A and zeroes a_out, b_out and op_out.
//    Clear beats next when both pulse in the same cycle. rst beats both.
//  - op_valid is registered: high only in the single ISSUE cycle, never in any other state.
//  - Unused encodings 5..7 recover to LOAD_A on the next edge with outputs zeroed.
//  - sw is sampled only on the next-pulse cycle; changes at other times have no effect.
// CONFIGURATION
//  OPSEQ_DEBOUNCE_EN defined:
//    - Each button also needs its sync2 level constant for DEBOUNCE_CYCLES consecutive
//      cycles before the filtered level changes. The edge is taken on the filtered level.
//    - Added latency = DEBOUNCE_CYCLES cycles.
//    - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
//  OPSEQ_DEBOUNCE_EN undefined:
//    - Synchroniser + edge detect only.
//    - Every clean rising level produces one pulse, including 1-cycle glitches.
//    - DEBOUNCE_CYCLES is unused.
// STRUCTURE
//  - Shared package/include ula_defs:
//    - state localparams ST_LOAD_A..ST_SHOW;
//    - opcode constants OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3, OP_ADD=4, OP_SUB=5;
//    - default WIDTH.
//  - Sub-module ula_btn_edge (sync + optional debounce + edge pulse), one instance per
//    button. FSM and operand registers stay in this module.
// TESTING
//  1 rst held 2 cycles mid-LOAD_B -> a_out=b_out=op_out=0, state_out=0, op_valid=0.
//  2 sw=4'hA next, sw=4'h6 next, sw=3'b000 next -> a_out=A, b_out=6, op_out=0,
//    op_valid high exactly 1 cycle, then state_out=4 and downstream AND shows 4'h2.
//  3 btn_next held high 50 cycles in LOAD_A -> exactly one capture; state_out=1.
//  4 next and clear rise in the same cycle while in LOAD_OP -> state_out=0, all outputs 0,
//    no op_valid.
//  5 In SHOW, change sw without pressing -> outputs unchanged. Then press next ->
//    state_out=0, old a_out retained until the next capture.
//  6 Debounce build (DEBOUNCE_CYCLES=16): a 5-cycle next glitch gives no state change;
//    20-cycle high gives one advance 16+3 edges after the rise.
//    Non-debounce build: the 5-cycle glitch advances the FSM.

Source files
------------

// File: rtl/ula_operand_sequencer_pkg.sv
// ula_operand_sequencer_pkg: shared state codes, opcode constants and default widths for the ULA operand sequencer
package ula_operand_sequencer_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_OPW = 3;
  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_ISSUE   = 3'd3,
    ST_SHOW    = 3'd4
  } state_e;
  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_NOT = 3'd3;
  localparam logic [2:0] OP_ADD = 3'd4;
  localparam logic [2:0] OP_SUB = 3'd5;
endpackage

// File: rtl/ula_operand_sequencer_if.sv
// ula_operand_sequencer_if: switch/button inputs and operand/status outputs of the operand sequencer
interface ula_operand_sequencer_if import ula_operand_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW = DEF_OPW
);
  logic [WIDTH-1:0] sw;
  logic btn_next;
  logic btn_clear;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [OPW-1:0] op_out;
  logic op_valid;
  logic [2:0] state_out;
  modport master (output sw, btn_next, btn_clear, input a_out, b_out, op_out, op_valid, state_out);
  modport slave (input sw, btn_next, btn_clear, output a_out, b_out, op_out, op_valid, state_out);
endinterface

// File: rtl/ula_operand_sequencer_btn_edge.sv
// ula_operand_sequencer_btn_edge: 2-flop sync, optional debounce (OPSEQ_DEBOUNCE_EN), rising-edge press pulse
module ula_operand_sequencer_btn_edge #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  logic s1_q, s2_q, prev_q, lvl;
  if (DEBOUNCE_CYCLES < 1) begin : g_chk
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
`ifdef OPSEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  logic filt_q;
  // filtered level follows sync2 only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      filt_q <= 1'b0;
    end else if (s2_q == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_q <= '0;
      filt_q <= s2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      prev_q <= lvl;
    end
  end
  assign pulse_o = lvl & ~prev_q;
endmodule

// File: rtl/ula_operand_sequencer.sv
// ula_operand_sequencer: captures A, B and opcode from a shared switch bus over three NEXT presses (debounce: OPSEQ_DEBOUNCE_EN)
module ula_operand_sequencer import ula_operand_sequencer_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OPW = DEF_OPW,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  ula_operand_sequencer_if.slave bus
);
  if (OPW > WIDTH) begin : g_chk
    $error("OPW must not exceed WIDTH");
  end
  logic next_p, clear_p;
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic valid_q, valid_d;
  ula_operand_sequencer_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk(clk), .rst(rst), .btn_i(bus.btn_next), .pulse_o(next_p)
  );
  ula_operand_sequencer_btn_edge #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clk(clk), .rst(rst), .btn_i(bus.btn_clear), .pulse_o(clear_p)
  );
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    case (state_q)
      ST_LOAD_A: if (next_p) begin
        a_d = bus.sw;
        state_d = ST_LOAD_B;
      end
      ST_LOAD_B: if (next_p) begin
        b_d = bus.sw;
        state_d = ST_LOAD_OP;
      end
      ST_LOAD_OP: if (next_p) begin
        op_d = bus.sw[OPW-1:0];
        state_d = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_SHOW;
      ST_SHOW: state_d = next_p ? ST_LOAD_A : ST_SHOW;
      default: begin
        state_d = ST_LOAD_A;
        a_d = '0;
        b_d = '0;
        op_d = '0;
      end
    endcase
    // the single ISSUE cycle ignores every button, clear included
    if (clear_p && state_q != ST_ISSUE) begin
      state_d = ST_LOAD_A;
      a_d = '0;
      b_d = '0;
      op_d = '0;
    end
    valid_d = state_d == ST_ISSUE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD_A;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      valid_q <= valid_d;
    end
  end
  assign bus.a_out = a_q;
  assign bus.b_out = b_q;
  assign bus.op_out = op_q;
  assign bus.op_valid = valid_q;
  assign bus.state_out = state_q;
endmodule
